// File: rtl/hub_slot_sched.sv
// hub_slot_sched -- time-slot hub arbiter for up to eight cogs.
//
// The hub bus runs at half the cog clock: ena_bus toggles every clk_cog edge
// and each edge where ena_bus was high before the edge is an "advance". On an
// advance, one entry of a 16-deep slot table is consulted. That entry names
// the cog that owns the bus for this slot. When reclaim is set and the owner
// cannot use the slot, the slot goes to another requesting cog. Those cogs
// are picked in round-robin order.
//
// Ports
//   clk_cog    in   cog clock, all state changes on its rising edge
//   res        in   asynchronous active-high reset
//   req[7:0]   in   per-cog hub request level
//   cog_ena    in   per-cog running flag
//   reclaim    in   give unused slots to other requesters
//   tbl_last   in   index of last active table entry (table wraps after it)
//   cfg_we     in   slot-table write strobe
//   cfg_addr   in   slot-table write index
//   cfg_data   in   table entry {valid, owner[2:0]}
//   ena_bus    out  bus phase enable, toggles every clock
//   bus_sel    out  one-hot grant, zero when nobody is granted
//   slot       out  table index used for the current grant
//   reclaimed  out  current grant came from reclaim, not the table owner
module hub_slot_sched #(
    parameter int NUMCOGS = 8,
    parameter int SLOTS   = 16
) (
    input  logic       clk_cog,
    input  logic       res,
    input  logic [7:0] req,
    input  logic [7:0] cog_ena,
    input  logic       reclaim,
    input  logic [3:0] tbl_last,
    input  logic       cfg_we,
    input  logic [3:0] cfg_addr,
    input  logic [3:0] cfg_data,
    output logic       ena_bus,
    output logic [7:0] bus_sel,
    output logic [3:0] slot,
    output logic       reclaimed
);

    logic [3:0] table_reg [SLOTS];
    logic [3:0] ptr_reg;
    logic [2:0] rr_reg;
    logic       ena_bus_reg;
    logic [7:0] bus_sel_reg;
    logic [3:0] slot_reg;
    logic       reclaimed_reg;

    // Cogs at or above NUMCOGS are not populated and must never be granted.
    logic [7:0] cog_mask;
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_mask
            assign cog_mask[gi] = (gi < NUMCOGS);
        end
    endgenerate

    // Shrinking tbl_last below ptr restarts the pass at entry 0.
    logic [3:0] eff;
    logic [3:0] ptr_next;
    logic [3:0] entry;
    logic [2:0] owner;
    logic       owner_ok;
    logic [7:0] cand;

    assign eff      = (ptr_reg > tbl_last) ? 4'd0 : ptr_reg;
    assign ptr_next = (eff == tbl_last) ? 4'd0 : eff + 4'd1;
    assign entry    = table_reg[eff];
    assign owner    = entry[2:0];
    // With reclaim off the owner keeps its slot even when idle; with reclaim
    // on an idle owner forfeits it.
    assign owner_ok = entry[3] && cog_mask[owner] && cog_ena[owner]
                      && (req[owner] || !reclaim);
    assign cand     = req & cog_ena & cog_mask;

    // Round-robin search starting at rr, wrapping 7 -> 0.
    logic       found;
    logic [2:0] winner;
    logic [2:0] idx;
    always_comb begin
        found  = 1'b0;
        winner = 3'd0;
        idx    = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = rr_reg + 3'(k);
            if (!found && cand[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    logic       reclaim_hit;
    logic [7:0] grant;
    logic       grant_reclaimed;
    always_comb begin
        reclaim_hit     = 1'b0;
        grant           = 8'd0;
        grant_reclaimed = 1'b0;
        if (owner_ok) begin
            grant = 8'd1 << owner;
        end else if (reclaim && found) begin
            reclaim_hit     = 1'b1;
            grant           = 8'd1 << winner;
            grant_reclaimed = 1'b1;
        end
    end

    always_ff @(posedge clk_cog or posedge res) begin
        if (res) begin
            ena_bus_reg   <= 1'b0;
            bus_sel_reg   <= 8'd0;
            slot_reg      <= 4'd0;
            reclaimed_reg <= 1'b0;
            ptr_reg       <= 4'd0;
            rr_reg        <= 3'd0;
        end else begin
            ena_bus_reg <= ~ena_bus_reg;
            if (ena_bus_reg) begin
                slot_reg      <= eff;
                ptr_reg       <= ptr_next;
                bus_sel_reg   <= grant;
                reclaimed_reg <= grant_reclaimed;
                if (reclaim_hit) begin
                    rr_reg <= winner + 3'd1;
                end
            end
        end
    end

    // The table is held in flops so reset can load the identity pattern.
    // A write on an advance edge lands after the advance has read the old
    // value, so the new entry takes effect on its next use.
    always_ff @(posedge clk_cog or posedge res) begin
        if (res) begin
            for (int i = 0; i < SLOTS; i++) begin
                table_reg[i] <= {1'b1, 3'(i)};
            end
        end else if (cfg_we) begin
            table_reg[cfg_addr] <= cfg_data;
        end
    end

    assign ena_bus   = ena_bus_reg;
    assign bus_sel   = bus_sel_reg;
    assign slot      = slot_reg;
    assign reclaimed = reclaimed_reg;

endmodule

// File: tb/tb_hub_slot_sched.sv
// Directed bench for hub_slot_sched: reset behaviour, table rotation,
// short tables, reclaim with round-robin, table-length shrink, write
// ordering against an advance and asynchronous reset mid-pass.
module tb_hub_slot_sched;

    logic       clk_cog = 1'b0;
    logic       res;
    logic [7:0] req;
    logic [7:0] cog_ena;
    logic       reclaim;
    logic [3:0] tbl_last;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [3:0] cfg_data;
    logic       ena_bus;
    logic [7:0] bus_sel;
    logic [3:0] slot;
    logic       reclaimed;

    int checks = 0;
    int errors = 0;

    hub_slot_sched #(.NUMCOGS(8), .SLOTS(16)) dut (
        .clk_cog   (clk_cog),
        .res       (res),
        .req       (req),
        .cog_ena   (cog_ena),
        .reclaim   (reclaim),
        .tbl_last  (tbl_last),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .ena_bus   (ena_bus),
        .bus_sel   (bus_sel),
        .slot      (slot),
        .reclaimed (reclaimed)
    );

    always #5 clk_cog = ~clk_cog;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk_cog);
        #1;
    endtask

    // Hold reset across one edge and release just after it; the following
    // edge is edge 1 (ena_bus rises) and the one after is the first advance.
    task automatic do_reset();
        res = 1'b1;
        #1;
        step();
        res = 1'b0;
    endtask

    // Step to the next advance edge (two clocks).
    task automatic adv();
        step();
        step();
    endtask

    logic [7:0] exp_sel_a [8];
    logic       exp_rec_a [8];

    initial begin
        res = 1'b1; req = 8'h00; cog_ena = 8'hFF; reclaim = 1'b0;
        tbl_last = 4'd7; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 4'd0;
        #2;
        check("rst_ena_bus", {7'd0, ena_bus}, 8'h00);
        check("rst_bus_sel", bus_sel, 8'h00);
        check("rst_slot", {4'd0, slot}, 8'h00);
        check("rst_reclaimed", {7'd0, reclaimed}, 8'h00);

        // Rotation through the identity table, tbl_last=7.
        step();
        res = 1'b0;
        step();
        check("rot_edge1_ena", {7'd0, ena_bus}, 8'h01);
        check("rot_edge1_sel", bus_sel, 8'h00);
        step();
        check("rot_edge2_ena", {7'd0, ena_bus}, 8'h00);
        check("rot_edge2_sel", bus_sel, 8'h01);
        check("rot_edge2_slot", {4'd0, slot}, 8'h00);
        for (int i = 1; i < 8; i++) begin
            step();
            check("rot_hold_sel", bus_sel, 8'h01 << (i - 1));
            step();
            check("rot_sel", bus_sel, 8'h01 << i);
            check("rot_slot", {4'd0, slot}, 8'(i));
            check("rot_rec", {7'd0, reclaimed}, 8'h00);
        end
        adv();
        check("rot_wrap_sel", bus_sel, 8'h01);
        check("rot_wrap_slot", {4'd0, slot}, 8'h00);

        // Asynchronous reset mid-pass.
        adv();
        check("mid_pre_sel", bus_sel, 8'h02);
        res = 1'b1;
        #1;
        check("mid_rst_sel", bus_sel, 8'h00);
        check("mid_rst_ena", {7'd0, ena_bus}, 8'h00);
        check("mid_rst_slot", {4'd0, slot}, 8'h00);

        // Short table {0:0,1:0,2:1}, tbl_last=2, cog_ena=03.
        cog_ena = 8'h03; tbl_last = 4'd2;
        do_reset();
        cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = 4'h8;
        step();
        cfg_addr = 4'd2; cfg_data = 4'h9;
        step();
        cfg_we = 1'b0;
        check("short_0", bus_sel, 8'h01);
        adv();
        check("short_1", bus_sel, 8'h01);
        adv();
        check("short_2", bus_sel, 8'h02);
        adv();
        check("short_3", bus_sel, 8'h01);
        check("short_3_slot", {4'd0, slot}, 8'h00);
        adv();
        check("short_4", bus_sel, 8'h01);
        adv();
        check("short_5", bus_sel, 8'h02);

        // Only cog 0 running, reclaim off, no requests.
        cog_ena = 8'h01; tbl_last = 4'd7; req = 8'h00; reclaim = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            adv();
            check("solo_sel", bus_sel, (i == 0) ? 8'h01 : 8'h00);
            check("solo_rec", {7'd0, reclaimed}, 8'h00);
        end

        // Reclaim with a single requester (cog 2).
        cog_ena = 8'hFF; req = 8'h04; reclaim = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            adv();
            check("rcl_sel", bus_sel, 8'h04);
            check("rcl_rec", {7'd0, reclaimed}, (i == 2) ? 8'h00 : 8'h01);
        end

        // Round-robin between cogs 4 and 6, only those two running.
        exp_sel_a = '{8'h10, 8'h40, 8'h10, 8'h40, 8'h10, 8'h10, 8'h40, 8'h40};
        exp_rec_a = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        cog_ena = 8'h50; req = 8'h50; reclaim = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            adv();
            check("rr_sel", bus_sel, exp_sel_a[i]);
            check("rr_rec", {7'd0, reclaimed}, {7'd0, exp_rec_a[i]});
        end

        // Shrink tbl_last below ptr=5.
        cog_ena = 8'hFF; req = 8'h00; reclaim = 1'b0; tbl_last = 4'd7;
        do_reset();
        for (int i = 0; i < 5; i++) adv();
        check("shr_pre_slot", {4'd0, slot}, 8'h04);
        tbl_last = 4'd3;
        adv();
        check("shr_slot", {4'd0, slot}, 8'h00);
        check("shr_sel", bus_sel, 8'h01);
        for (int i = 0; i < 3; i++) adv();
        check("shr_last_slot", {4'd0, slot}, 8'h03);
        adv();
        check("shr_wrap_slot", {4'd0, slot}, 8'h00);

        // Write entry 0 on the edge where entry 0 advances.
        tbl_last = 4'd7;
        do_reset();
        step();
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 4'hE;
        step();
        cfg_we = 1'b0;
        check("wr_old_sel", bus_sel, 8'h01);
        check("wr_old_slot", {4'd0, slot}, 8'h00);
        for (int i = 0; i < 7; i++) adv();
        check("wr_s7_sel", bus_sel, 8'h80);
        adv();
        check("wr_new_sel", bus_sel, 8'h40);
        check("wr_new_slot", {4'd0, slot}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
